// File: rtl/spi_pkg.sv
// Shared definitions for the SPI read/write data paths: header layout and frame FSM encodings.
// The header is the sync byte in the top bits of the word and the payload length in the low 16 bits.
package spi_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  localparam int HDR_SYNC_W  = 8;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: registered storage, combinational head read, one cycle write-to-empty-flag.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in cnt_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_rx_frame_buffer.sv
// Frame hunter and payload buffer behind the SPI read path; payload reaches m_tvalid_o one cycle after its strobe.
// Sink backpressure fills the FIFO, rd_req_o drops once headroom runs out, words arriving on a full FIFO are dropped.
module spi_rx_frame_buffer
  import spi_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter int         HEADROOM   = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          clr_i,
  input  logic [DATA_WIDTH-1:0]         sdi_data_i,
  input  logic                          sdi_valid_i,
  output logic                          rd_req_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tvalid_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   frame_cnt_o,
  output logic [15:0]                   sync_err_cnt_o,
  output logic                          ovf_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]            state_q, state_d;
  logic [HDR_LEN_W-1:0]  rem_q, rem_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           sync_err_q, sync_err_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_req_q, rd_req_d;

  logic                  evt;
  logic                  is_hdr;
  logic [HDR_LEN_W-1:0]  hdr_len;
  logic                  fifo_push, fifo_last, fifo_pop;
  logic                  fifo_full, fifo_empty, push_ok;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [LW-1:0]         level, level_next;
  logic                  unused_hdr_bits;

  assign evt     = sdi_valid_i & enable_i;
  assign is_hdr  = (sdi_data_i[DATA_WIDTH-1 -: HDR_SYNC_W] == SYNC_BYTE);
  assign hdr_len = sdi_data_i[HDR_LEN_LSB +: HDR_LEN_W];
  assign unused_hdr_bits = ^sdi_data_i[DATA_WIDTH-HDR_SYNC_W-1 : HDR_LEN_LSB+HDR_LEN_W];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    frame_cnt_d = frame_cnt_q;
    sync_err_d  = sync_err_q;
    ovf_d       = ovf_q;
    fifo_push   = 1'b0;
    fifo_last   = 1'b0;
    if (evt) begin
      if (state_q == ST_HUNT) begin
        if (is_hdr) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (hdr_len != '0) begin
            state_d = ST_PAYLOAD;
            rem_d   = hdr_len;
          end
        end else if (sync_err_q != 16'hFFFF) begin
          sync_err_d = sync_err_q + 16'd1;
        end
      end else begin
        fifo_push = 1'b1;
        fifo_last = (rem_q == HDR_LEN_W'(1));
        rem_d     = rem_q - HDR_LEN_W'(1);
        if (rem_q == HDR_LEN_W'(1)) begin
          state_d = ST_HUNT;
        end
      end
    end
    // A dropped payload word still consumes its slot in the frame, keeping alignment.
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    if (clr_i) begin
      frame_cnt_d = '0;
      sync_err_d  = '0;
      ovf_d       = 1'b0;
    end
  end

  assign fifo_pop   = m_tvalid_o & m_tready_i;
  assign push_ok    = fifo_push & (~fifo_full | fifo_pop);
  assign level_next = level + LW'(push_ok) - LW'(fifo_pop);
  assign rd_req_d   = enable_i & ((FIFO_DEPTH - int'(level_next)) >= HEADROOM);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      rem_q       <= '0;
      frame_cnt_q <= '0;
      sync_err_q  <= '0;
      ovf_q       <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      frame_cnt_q <= frame_cnt_d;
      sync_err_q  <= sync_err_d;
      ovf_q       <= ovf_d;
      rd_req_q    <= rd_req_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({fifo_last, sdi_data_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Head storage is not reset, so mask it while empty to keep outputs at zero.
  assign m_tvalid_o     = ~fifo_empty;
  assign m_tdata_o      = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_tlast_o      = ~fifo_empty & fifo_dout[DATA_WIDTH];
  assign fifo_level_o   = level;
  assign frame_cnt_o    = frame_cnt_q;
  assign sync_err_cnt_o = sync_err_q;
  assign ovf_o          = ovf_q;
  assign rd_req_o       = rd_req_q;

endmodule
